// File: rtl/style_color_pkg.sv
// Shared types for style_color_apply_unit: request kind, FSM state and the
// packed request-control struct carried through the optional request FIFO.
package style_color_pkg;

    typedef enum logic [1:0] {
        KIND_VALUE    = 2'd0,
        KIND_INHERIT  = 2'd1,
        KIND_INITIAL  = 2'd2,
        KIND_RESERVED = 2'd3
    } req_kind_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_RESOLVE = 2'd2,
        ST_WRITE   = 2'd3
    } state_t;

    typedef struct packed {
        req_kind_t kind;
        logic      is_ident;
        logic      apply_regular;
        logic      apply_visited;
        logic      is_link;
    } req_ctrl_t;

endpackage

// File: rtl/style_color_apply_unit_fifo.sv
// style_color_req_fifo: parametrised synchronous request FIFO with full/empty;
// rdata shows the head entry, push while full is accepted when a pop happens too.
module style_color_req_fifo #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_wdata,
    input  logic         i_pop,
    output logic [W-1:0] o_rdata,
    output logic         o_full,
    output logic         o_empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == DEPTH[AW:0]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_rdata   = r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/style_color_apply_unit.sv
// Multi-property colour applier: IDLE -> FETCH -> RESOLVE -> WRITE per request.
// Define STYLE_COLOR_FIFO_EN to place a FIFO_DEPTH-entry request FIFO in front of the FSM.
module style_color_apply_unit
    import style_color_pkg::*;
#(
    parameter int unsigned          NUM_PROPS     = 8,
    parameter int unsigned          COLOR_W       = 32,
    parameter int unsigned          IDENT_W       = 10,
    parameter int unsigned          FIFO_DEPTH    = 4,
    parameter logic [COLOR_W-1:0]   INITIAL_COLOR = 32'h0000_00FF,
    localparam int unsigned         PW            = $clog2(NUM_PROPS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [PW-1:0]      req_prop,
    input  logic [1:0]         req_kind,
    input  logic               req_is_ident,
    input  logic [IDENT_W-1:0] req_ident,
    input  logic [COLOR_W-1:0] req_rgb,
    input  logic [COLOR_W-1:0] req_named_color,
    input  logic               req_apply_regular,
    input  logic               req_apply_visited,
    input  logic               req_is_link,
    input  logic [COLOR_W-1:0] doc_text_color,
    input  logic [COLOR_W-1:0] doc_link_color,
    input  logic [COLOR_W-1:0] doc_visited_link_color,
    input  logic [COLOR_W-1:0] doc_active_link_color,
    input  logic [IDENT_W-1:0] ident_currentcolor,
    input  logic [IDENT_W-1:0] ident_webkit_text,
    input  logic [IDENT_W-1:0] ident_webkit_link,
    input  logic [IDENT_W-1:0] ident_webkit_activelink,
    output logic               parent_rd_en,
    output logic [PW-1:0]      parent_rd_prop,
    input  logic [COLOR_W-1:0] parent_color,
    input  logic               parent_color_valid,
    input  logic [COLOR_W-1:0] parent_invalid_color,
    input  logic [PW-1:0]      rd_prop,
    output logic [COLOR_W-1:0] rd_color,
    output logic [COLOR_W-1:0] rd_visited_color,
    output logic               done,
    output logic               err
);
    localparam int unsigned CTRL_W       = $bits(req_ctrl_t);
    localparam int unsigned REQ_W        = PW + IDENT_W + 2 * COLOR_W + CTRL_W;
    localparam logic [PW:0] LP_NUM_PROPS = NUM_PROPS[PW:0];

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two >= 2");
    end

    state_t             r_state;
    logic [PW-1:0]      r_prop;
    logic [IDENT_W-1:0] r_ident;
    logic [COLOR_W-1:0] r_rgb;
    logic [COLOR_W-1:0] r_named;
    req_ctrl_t          r_ctrl;
    logic [COLOR_W-1:0] r_cand_reg;
    logic [COLOR_W-1:0] r_cand_vis;
    logic               r_err;
    logic [COLOR_W-1:0] r_color  [NUM_PROPS];
    logic [COLOR_W-1:0] r_vcolor [NUM_PROPS];

    req_ctrl_t          w_live_ctrl;
    logic [REQ_W-1:0]   w_live_req;
    logic [REQ_W-1:0]   w_src_req;
    logic               w_take;
    logic [PW-1:0]      w_s_prop;
    logic [IDENT_W-1:0] w_s_ident;
    logic [COLOR_W-1:0] w_s_rgb;
    logic [COLOR_W-1:0] w_s_named;
    req_ctrl_t          w_s_ctrl;
    logic [COLOR_W-1:0] w_inh;
    logic [COLOR_W-1:0] w_cand_reg;
    logic [COLOR_W-1:0] w_cand_vis;
    logic               w_err;
    logic               w_rd_ok;

    always_comb begin
        w_live_ctrl               = '0;
        w_live_ctrl.kind          = req_kind_t'(req_kind);
        w_live_ctrl.is_ident      = req_is_ident;
        w_live_ctrl.apply_regular = req_apply_regular;
        w_live_ctrl.apply_visited = req_apply_visited;
        w_live_ctrl.is_link       = req_is_link;
    end

    assign w_live_req = {req_prop, req_ident, req_rgb, req_named_color, w_live_ctrl};

`ifdef STYLE_COLOR_FIFO_EN
    logic w_full;
    logic w_empty;

    style_color_req_fifo #(
        .W     (REQ_W),
        .DEPTH (FIFO_DEPTH)
    ) u_req_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .i_push  (req_valid && req_ready),
        .i_wdata (w_live_req),
        .i_pop   (w_take),
        .o_rdata (w_src_req),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_take    = (r_state == ST_IDLE) && !w_empty;
    assign req_ready = reset && !w_full;
`else
    assign w_src_req = w_live_req;
    assign w_take    = (r_state == ST_IDLE) && req_valid;
    assign req_ready = reset && (r_state == ST_IDLE);
`endif

    assign {w_s_prop, w_s_ident, w_s_rgb, w_s_named, w_s_ctrl} = w_src_req;

    always_comb begin
        w_inh      = parent_color_valid ? parent_color : parent_invalid_color;
        w_cand_reg = '0;
        w_cand_vis = '0;
        w_err      = ({1'b0, r_prop} >= LP_NUM_PROPS) || (r_ctrl.kind == KIND_RESERVED);
        case (r_ctrl.kind)
            KIND_INHERIT: begin
                w_cand_reg = w_inh;
                w_cand_vis = w_inh;
            end
            KIND_INITIAL: begin
                w_cand_reg = INITIAL_COLOR;
                w_cand_vis = INITIAL_COLOR;
            end
            KIND_VALUE: begin
                if (!r_ctrl.is_ident) begin
                    w_cand_reg = r_rgb;
                end else if (r_ident == ident_currentcolor) begin
                    w_cand_reg = (r_prop == '0) ? w_inh : r_color[0];
                end else if (r_ident == ident_webkit_text) begin
                    w_cand_reg = doc_text_color;
                end else if (r_ident == ident_webkit_link) begin
                    w_cand_reg = doc_link_color;
                end else if (r_ident == ident_webkit_activelink) begin
                    w_cand_reg = doc_active_link_color;
                end else begin
                    w_cand_reg = r_named;
                end
                w_cand_vis = w_cand_reg;
                // Only the visited candidate distinguishes link elements for webkit-link.
                if (r_ctrl.is_ident && r_ident != ident_currentcolor && r_ident != ident_webkit_text &&
                    r_ident == ident_webkit_link && r_ctrl.is_link) begin
                    w_cand_vis = doc_visited_link_color;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_prop     <= '0;
            r_ident    <= '0;
            r_rgb      <= '0;
            r_named    <= '0;
            r_ctrl     <= '0;
            r_cand_reg <= '0;
            r_cand_vis <= '0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_take) begin
                        r_prop  <= w_s_prop;
                        r_ident <= w_s_ident;
                        r_rgb   <= w_s_rgb;
                        r_named <= w_s_named;
                        r_ctrl  <= w_s_ctrl;
                        r_state <= ST_FETCH;
                    end
                end
                ST_FETCH:   r_state <= ST_RESOLVE;
                ST_RESOLVE: begin
                    r_cand_reg <= w_cand_reg;
                    r_cand_vis <= w_cand_vis;
                    r_err      <= w_err;
                    r_state    <= ST_WRITE;
                end
                ST_WRITE:   r_state <= ST_IDLE;
                default:    r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_PROPS; i++) begin
                r_color[i]  <= '0;
                r_vcolor[i] <= '0;
            end
        end else if (r_state == ST_WRITE && !r_err) begin
            if (r_ctrl.apply_regular) r_color[r_prop]  <= r_cand_reg;
            if (r_ctrl.apply_visited) r_vcolor[r_prop] <= r_cand_vis;
        end
    end

    assign parent_rd_en     = (r_state == ST_FETCH);
    assign parent_rd_prop   = r_prop;
    assign done             = (r_state == ST_WRITE);
    assign err              = done && r_err;
    assign w_rd_ok          = ({1'b0, rd_prop} < LP_NUM_PROPS);
    assign rd_color         = w_rd_ok ? r_color[rd_prop]  : '0;
    assign rd_visited_color = w_rd_ok ? r_vcolor[rd_prop] : '0;

endmodule

// File: tb/tb_style_color_apply_unit.sv
// Self-checking bench for style_color_apply_unit (default build, or STYLE_COLOR_FIFO_EN).
module tb_style_color_apply_unit;
    localparam int unsigned NP = 6;
    localparam int unsigned PW = 3;
    localparam logic [31:0] INIT_C   = 32'h0000_00FF;
    localparam logic [9:0]  ID_CUR   = 10'd100;
    localparam logic [9:0]  ID_TEXT  = 10'd200;
    localparam logic [9:0]  ID_LINK  = 10'd300;
    localparam logic [9:0]  ID_ALINK = 10'd400;
`ifdef STYLE_COLOR_FIFO_EN
    localparam int unsigned LAT   = 4;
    localparam int unsigned NPUSH = 3;
`else
    localparam int unsigned LAT   = 3;
    localparam int unsigned NPUSH = 1;
`endif

    typedef struct {
        logic [PW-1:0] prop;
        logic [1:0]    kind;
        bit            is_ident;
        logic [9:0]    ident;
        logic [31:0]   rgb;
        logic [31:0]   named;
        bit            ar;
        bit            av;
        bit            link;
        bit            pvalid;
        logic [31:0]   pcol;
        logic [31:0]   pinv;
    } tr_t;

    logic clk = 1'b0;
    logic reset;
    logic req_valid, req_ready;
    logic [PW-1:0] req_prop;
    logic [1:0] req_kind;
    logic req_is_ident;
    logic [9:0] req_ident;
    logic [31:0] req_rgb, req_named_color;
    logic req_apply_regular, req_apply_visited, req_is_link;
    logic [31:0] doc_text_color, doc_link_color, doc_visited_link_color, doc_active_link_color;
    logic [9:0] ident_currentcolor, ident_webkit_text, ident_webkit_link, ident_webkit_activelink;
    logic parent_rd_en;
    logic [PW-1:0] parent_rd_prop;
    logic [31:0] parent_color, parent_invalid_color;
    logic parent_color_valid;
    logic [PW-1:0] rd_prop;
    logic [31:0] rd_color, rd_visited_color;
    logic done, err;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned n_fail   = 0;
    logic [31:0] m_reg [NP];
    logic [31:0] m_vis [NP];

    always #10 clk = ~clk;

    style_color_apply_unit #(
        .NUM_PROPS     (NP),
        .COLOR_W       (32),
        .IDENT_W       (10),
        .FIFO_DEPTH    (4),
        .INITIAL_COLOR (INIT_C)
    ) dut (
        .clk (clk), .reset (reset),
        .req_valid (req_valid), .req_ready (req_ready),
        .req_prop (req_prop), .req_kind (req_kind),
        .req_is_ident (req_is_ident), .req_ident (req_ident),
        .req_rgb (req_rgb), .req_named_color (req_named_color),
        .req_apply_regular (req_apply_regular), .req_apply_visited (req_apply_visited),
        .req_is_link (req_is_link),
        .doc_text_color (doc_text_color), .doc_link_color (doc_link_color),
        .doc_visited_link_color (doc_visited_link_color), .doc_active_link_color (doc_active_link_color),
        .ident_currentcolor (ident_currentcolor), .ident_webkit_text (ident_webkit_text),
        .ident_webkit_link (ident_webkit_link), .ident_webkit_activelink (ident_webkit_activelink),
        .parent_rd_en (parent_rd_en), .parent_rd_prop (parent_rd_prop),
        .parent_color (parent_color), .parent_color_valid (parent_color_valid),
        .parent_invalid_color (parent_invalid_color),
        .rd_prop (rd_prop), .rd_color (rd_color), .rd_visited_color (rd_visited_color),
        .done (done), .err (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic tr_t mk(input logic [PW-1:0] prop, input logic [1:0] kind, input bit is_ident,
                               input logic [9:0] ident, input logic [31:0] rgb, input bit ar, input bit av,
                               input bit link, input bit pvalid, input logic [31:0] pcol, input logic [31:0] pinv);
        tr_t t;
        t.prop = prop; t.kind = kind; t.is_ident = is_ident; t.ident = ident; t.rgb = rgb;
        t.named = $urandom(); t.ar = ar; t.av = av; t.link = link;
        t.pvalid = pvalid; t.pcol = pcol; t.pinv = pinv;
        return t;
    endfunction

    // Reference rules: what each style should receive for a request, given the model state.
    function automatic void expect_of(input tr_t t, output logic [31:0] er, output logic [31:0] ev, output bit eerr);
        logic [31:0] inh;
        inh  = t.pvalid ? t.pcol : t.pinv;
        eerr = (int'(t.prop) >= int'(NP)) || (t.kind == 2'd3);
        er = '0;
        ev = '0;
        if (t.kind == 2'd1) begin
            er = inh; ev = inh;
        end else if (t.kind == 2'd2) begin
            er = INIT_C; ev = INIT_C;
        end else if (t.kind == 2'd0) begin
            if (!t.is_ident)             begin er = t.rgb; ev = t.rgb; end
            else if (t.ident == ID_CUR)  begin er = (t.prop == 0) ? inh : m_reg[0]; ev = er; end
            else if (t.ident == ID_TEXT) begin er = doc_text_color; ev = er; end
            else if (t.ident == ID_LINK) begin
                er = doc_link_color;
                ev = t.link ? doc_visited_link_color : doc_link_color;
            end
            else if (t.ident == ID_ALINK) begin er = doc_active_link_color; ev = er; end
            else                         begin er = t.named; ev = t.named; end
        end
    endfunction

    task automatic apply_model(input tr_t t);
        logic [31:0] er, ev;
        bit eerr;
        expect_of(t, er, ev, eerr);
        if (!eerr) begin
            if (t.ar) m_reg[t.prop] = er;
            if (t.av) m_vis[t.prop] = ev;
        end
    endtask

    task automatic drive(input tr_t t);
        req_prop = t.prop; req_kind = t.kind; req_is_ident = t.is_ident; req_ident = t.ident;
        req_rgb = t.rgb; req_named_color = t.named; req_apply_regular = t.ar;
        req_apply_visited = t.av; req_is_link = t.link;
        parent_color = t.pcol; parent_color_valid = t.pvalid; parent_invalid_color = t.pinv;
    endtask

    task automatic sweep(input string tag);
        for (int i = 0; i < int'(NP); i++) begin
            rd_prop = PW'(i);
            #1;
            chk({tag, "_rd"}, rd_color, m_reg[i]);
            chk({tag, "_rdv"}, rd_visited_color, m_vis[i]);
        end
        @(negedge clk);
    endtask

    task automatic do_req(input string tag, input tr_t t);
        logic [31:0] er, ev, old_r, old_v;
        bit eerr, fetch_seen;
        logic [PW-1:0] fetch_prop;
        int unsigned cyc, lat;
        expect_of(t, er, ev, eerr);
        @(negedge clk);
        drive(t);
        rd_prop = t.prop;
        req_valid = 1'b1;
        cyc = 0;
        while (!req_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_ready"}, 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        req_rgb = $urandom(); req_named_color = $urandom(); req_is_link = !t.link;
        req_apply_regular = !t.ar; req_apply_visited = !t.av;
        lat = 1;
        fetch_seen = 0;
        fetch_prop = '0;
        while (!done && lat < 20) begin
            if (parent_rd_en) begin fetch_seen = 1; fetch_prop = parent_rd_prop; end
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, lat, LAT);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_err"}, 32'(err), 32'(eerr));
        chk({tag, "_fetch"}, {31'd0, fetch_seen}, 32'd1);
        chk({tag, "_fetchprop"}, 32'(fetch_prop), 32'(t.prop));
        if (int'(t.prop) < int'(NP)) begin
            old_r = m_reg[t.prop];
            old_v = m_vis[t.prop];
            chk({tag, "_oldrd"}, rd_color, old_r);
            chk({tag, "_oldrdv"}, rd_visited_color, old_v);
        end
        apply_model(t);
        @(negedge clk);
        chk({tag, "_donelow"}, 32'(done), 32'd0);
        if (int'(t.prop) < int'(NP)) begin
            chk({tag, "_rd"}, rd_color, m_reg[t.prop]);
            chk({tag, "_rdv"}, rd_visited_color, m_vis[t.prop]);
        end
    endtask

    task automatic stream6();
        tr_t q[6];
        int unsigned k, dn, cyc, last_done;
        bit saw_block, go;
        for (int i = 0; i < 6; i++) q[i] = mk(PW'(i % 3), 2'd0, 0, 10'd0, $urandom(), 1, 1, 0, 1, 32'h0, 32'h0);
        k = 0; dn = 0; cyc = 0; last_done = 0; saw_block = 0;
        @(negedge clk);
        while ((k < 6 || dn < 6) && cyc < 300) begin
            if (done) begin
                chk("stream_err", 32'(err), 32'd0);
                if (dn > 0) chk("stream_gap", cyc - last_done, 32'd4);
                last_done = cyc;
                dn++;
            end
            go = 0;
            if (k < 6) begin
                drive(q[k]);
                req_valid = 1'b1;
                go = req_ready;
                if (!go) saw_block = 1;
            end else begin
                req_valid = 1'b0;
            end
            @(negedge clk);
            cyc++;
            if (go) k++;
        end
        req_valid = 1'b0;
        chk("stream_accepted", k, 32'd6);
        chk("stream_dones", dn, 32'd6);
        chk("stream_ready_low", {31'd0, saw_block}, 32'd1);
        for (int i = 0; i < 6; i++) apply_model(q[i]);
        sweep("stream");
    endtask

    initial begin
        tr_t t;
        int unsigned k, dn, cyc;
        bit go;
        reset = 1'b0; req_valid = 1'b0; rd_prop = '0;
        drive(mk('0, 2'd0, 0, 10'd0, 32'h0, 0, 0, 0, 0, 32'h0, 32'h0));
        ident_currentcolor = ID_CUR; ident_webkit_text = ID_TEXT;
        ident_webkit_link = ID_LINK; ident_webkit_activelink = ID_ALINK;
        doc_text_color = 32'h1010_10FF; doc_link_color = 32'h0000_00AA;
        doc_visited_link_color = 32'h0000_00BB; doc_active_link_color = 32'hCAFE_0001;
        for (int i = 0; i < int'(NP); i++) begin m_reg[i] = '0; m_vis[i] = '0; end

        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_prd", 32'(parent_rd_en), 32'd0);
        sweep("rst");
        reset = 1'b1;
        @(negedge clk);

        do_req("rgb", mk(3'd2, 2'd0, 0, 10'd0, 32'h1122_3344, 1, 1, 0, 1, 32'h5555_5555, 32'h6666_6666));
        do_req("inh_inv", mk(3'd1, 2'd1, 0, 10'd0, 32'h0, 1, 1, 0, 0, 32'h1234_5678, 32'hDEAD_BEEF));
        do_req("set_c0", mk(3'd0, 2'd0, 0, 10'd0, 32'hFF00_00FF, 1, 1, 0, 1, 32'h0, 32'h0));
        do_req("cur_p3", mk(3'd3, 2'd0, 1, ID_CUR, 32'h0, 1, 1, 0, 1, 32'h0BAD_0BAD, 32'h0));
        do_req("cur_p0", mk(3'd0, 2'd0, 1, ID_CUR, 32'h0, 1, 1, 0, 1, 32'h00FF_00FF, 32'h0));
        do_req("link_both", mk(3'd4, 2'd0, 1, ID_LINK, 32'h0, 1, 1, 1, 1, 32'h0, 32'h0));
        doc_link_color = 32'h0000_00CC;
        do_req("link_reg", mk(3'd4, 2'd0, 1, ID_LINK, 32'h0, 1, 0, 0, 1, 32'h0, 32'h0));
        do_req("initial", mk(3'd5, 2'd2, 0, 10'd0, 32'h0, 1, 1, 0, 1, 32'h0, 32'h0));
        do_req("no_en", mk(3'd2, 2'd0, 0, 10'd0, 32'h7777_7777, 0, 0, 0, 1, 32'h0, 32'h0));
        do_req("err_prop", mk(PW'(NP), 2'd0, 0, 10'd0, 32'h9999_9999, 1, 1, 0, 1, 32'h0, 32'h0));
        do_req("err_kind", mk(3'd1, 2'd3, 0, 10'd0, 32'h8888_8888, 1, 1, 0, 1, 32'h0, 32'h0));
        sweep("directed");

        for (int n = 0; n < 40; n++) begin
            logic [9:0] ids [5];
            ids[0] = ID_CUR; ids[1] = ID_TEXT; ids[2] = ID_LINK; ids[3] = ID_ALINK;
            ids[4] = 10'(500 + $urandom_range(0, 63));
            doc_text_color = $urandom(); doc_link_color = $urandom();
            doc_visited_link_color = $urandom(); doc_active_link_color = $urandom();
            t = mk(PW'($urandom_range(0, 6)), 2'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
                   ids[$urandom_range(0, 4)], $urandom(), bit'($urandom_range(0, 1)),
                   bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                   $urandom(), $urandom());
            do_req("rand", t);
        end
        sweep("random");

        stream6();

        // Abort: accept some requests, then reset before any completes.
        k = 0; dn = 0; cyc = 0;
        @(negedge clk);
        while (k < NPUSH && cyc < 50) begin
            if (done) dn++;
            drive(mk(PW'(k), 2'd0, 0, 10'd0, $urandom(), 1, 1, 0, 1, 32'h0, 32'h0));
            req_valid = 1'b1;
            go = req_ready;
            @(negedge clk);
            cyc++;
            if (go) k++;
        end
        req_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk("abort_ready", 32'(req_ready), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (done) dn++;
            @(negedge clk);
        end
        chk("abort_no_done", dn, 32'd0);
        for (int i = 0; i < int'(NP); i++) begin m_reg[i] = '0; m_vis[i] = '0; end
        sweep("abort");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
